gpio_mmio_port: RTL and testbench

- Memory-mapped GPIO peripheral that sits between the board switches/LEDs and the mips core's data bus.
- Input path:
  - synchronises the raw switch inputs;
  - debounces them;
  - records rising edges in sticky flags.
- Output path: drives the LED register and a level interrupt.
- Consumes raw pins on gpio_i and produces the 8-bit output pattern on gpio_o that the core's GPIO_o reflects.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_debounce_bit.sv | 57 +++++
 rtl/gpio_mmio_port.sv | 94 +++++++++
 tb/tb_gpio_mmio_port.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the memory-mapped GPIO port:
//   - word offsets of the four registers seen on the data bus
//   - default widths and debounce length used by gpio_mmio_port
package gpio_pkg;

   // Register word offsets (addr_i)
   localparam logic [1:0] GPIO_IN    = 2'd0;   // debounced pin levels, read-only
   localparam logic [1:0] GPIO_OUT   = 2'd1;   // LED / output pin register
   localparam logic [1:0] GPIO_EDGE  = 2'd2;   // sticky rising-edge flags, W1C
   localparam logic [1:0] GPIO_IRQEN = 2'd3;   // per-bit interrupt enable

   // Defaults
   localparam int GPIO_DATA_W_DEF   = 32;
   localparam int GPIO_W_DEF        = 8;
   localparam int GPIO_DEBOUNCE_DEF = 4;

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
// One input pin: two-flop synchroniser, consecutive-stable counter and the
// accepted (debounced) level. A change is accepted once the synchronised
// value has differed from the accepted level for DEBOUNCE_CYCLES edges in a row.
// Ports:
//   clk_i     system clock
//   reset_i   asynchronous active-low reset
//   pin_i     raw asynchronous pin
//   stable_o  debounced level
//   rise_o    high during the cycle whose closing edge accepts a 0->1 change
module gpio_debounce_bit
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic pin_i,
   output logic stable_o,
   output logic rise_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1 <= pin_i;
         r_s2 <= r_s1;
         // Any return to the accepted level restarts the count.
         if (r_s2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end
      end
   end

   assign stable_o = r_stable;
   // Combinational look-ahead so the edge flag sets on the same clock edge
   // that stable goes high.
   assign rise_o   = r_s2 & ~r_stable & (r_cnt == CNT_MAX);

endmodule : gpio_debounce_bit

// File: rtl/gpio_mmio_port.sv
// gpio_mmio_port
// Memory-mapped GPIO peripheral: debounced switch inputs with sticky
// rising-edge flags, an output pin register and a level interrupt.
// Ports:
//   clk_i     system clock
//   reset_i   asynchronous active-low reset
//   sel_i     bus select
//   we_i      write enable (qualified by sel_i)
//   addr_i    word offset: IN, OUT, EDGE, IRQ_EN
//   wdata_i   write data (upper DATA_W-GPIO_W bits ignored)
//   rdata_o   combinational read data, zero when not selected
//   gpio_i    raw pin inputs
//   gpio_o    output pin register
//   irq_o     |(EDGE & IRQ_EN)
module gpio_mmio_port
   import gpio_pkg::*;
#(
   parameter int DATA_W          = GPIO_DATA_W_DEF,
   parameter int GPIO_W          = GPIO_W_DEF,
   parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              sel_i,
   input  logic              we_i,
   input  logic [1:0]        addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic              irq_o
);

   logic [GPIO_W-1:0] w_stable;
   logic [GPIO_W-1:0] w_rise;
   logic [GPIO_W-1:0] w_wbits;
   logic [GPIO_W-1:0] w_clr;
   logic              w_wr;
   logic              w_unused_wdata;

   logic [GPIO_W-1:0] r_out;
   logic [GPIO_W-1:0] r_edge;
   logic [GPIO_W-1:0] r_irq_en;

   genvar gi;
   generate
      for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
         gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_db (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .pin_i    (gpio_i[gi]),
            .stable_o (w_stable[gi]),
            .rise_o   (w_rise[gi])
         );
      end
   endgenerate

   assign w_wr    = sel_i & we_i;
   assign w_wbits = wdata_i[GPIO_W-1:0];
   assign w_clr   = (w_wr && addr_i == GPIO_EDGE) ? w_wbits : '0;
   // Upper write bits carry no state.
   assign w_unused_wdata = ^wdata_i;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_out    <= '0;
         r_edge   <= '0;
         r_irq_en <= '0;
      end else begin
         if (w_wr && addr_i == GPIO_OUT)   r_out    <= w_wbits;
         if (w_wr && addr_i == GPIO_IRQEN) r_irq_en <= w_wbits;
         // Set after clear: a new rise on the clearing edge is not lost.
         r_edge <= (r_edge & ~w_clr) | w_rise;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (sel_i) begin
         case (addr_i)
            GPIO_IN:    rdata_o[GPIO_W-1:0] = w_stable;
            GPIO_OUT:   rdata_o[GPIO_W-1:0] = r_out;
            GPIO_EDGE:  rdata_o[GPIO_W-1:0] = r_edge;
            default:    rdata_o[GPIO_W-1:0] = r_irq_en;
         endcase
      end
   end

   assign gpio_o = r_out;
   assign irq_o  = |(r_edge & r_irq_en);

endmodule : gpio_mmio_port

// File: tb/tb_gpio_mmio_port.sv
// tb_gpio_mmio_port
// Directed test of gpio_mmio_port with the default parameters
// (DATA_W=32, GPIO_W=8, DEBOUNCE_CYCLES=4).
module tb_gpio_mmio_port;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        sel_i;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic [7:0]  gpio_i;
   logic [7:0]  gpio_o;
   logic        irq_o;

   int passed = 0;
   int total  = 0;
   logic [31:0] rd_val;

   localparam logic [1:0] A_IN = 2'd0, A_OUT = 2'd1, A_EDGE = 2'd2, A_IRQEN = 2'd3;

   gpio_mmio_port #(
      .DATA_W          (32),
      .GPIO_W          (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .sel_i   (sel_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .irq_o   (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %s: observed %h expected %h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; land 1 time unit after the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      sel_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      #1;
      d      = rdata_o;
      sel_i  = 1'b0;
   endtask

   // Write takes effect on the next clock edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel_i   = 1'b1;
      we_i    = 1'b1;
      addr_i  = a;
      wdata_i = d;
      tick(1);
      sel_i   = 1'b0;
      we_i    = 1'b0;
      wdata_i = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b0;
      sel_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = 2'd0;
      wdata_i = 32'h0;
      gpio_i  = 8'hFF;

      // Reset held 3 cycles with all pins high.
      tick(3);
      chk("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
      rd(A_OUT, rd_val);   chk("rst_out", rd_val, 32'h0);
      rd(A_IN, rd_val);    chk("rst_in", rd_val, 32'h0);
      reset_i = 1'b1;
      // First edge after release is k; acceptance on edge k+5.
      tick(5);
      rd(A_IN, rd_val);    chk("in_before_accept", rd_val, 32'h0);
      tick(1);
      rd(A_IN, rd_val);    chk("in_accept_ff", rd_val, 32'h0000_00FF);
      rd(A_EDGE, rd_val);  chk("edge_after_rst", rd_val, 32'h0000_00FF);
      addr_i = A_EDGE;
      #1;
      chk("sel0_reads_zero", rdata_o, 32'h0);
      wr(A_EDGE, 32'hFFFF_FFFF);
      rd(A_EDGE, rd_val);  chk("edge_w1c_all", rd_val, 32'h0);

      // OUT register, read-during-write, write to IN ignored.
      sel_i = 1'b1; we_i = 1'b1; addr_i = A_OUT; wdata_i = 32'hDEAD_BEA5;
      #1;
      chk("out_read_prewrite", rdata_o, 32'h0);
      tick(1);
      sel_i = 1'b0; we_i = 1'b0;
      chk("gpio_o_a5", {24'h0, gpio_o}, 32'h0000_00A5);
      rd(A_OUT, rd_val);   chk("out_read_a5", rd_val, 32'h0000_00A5);
      wr(A_IN, 32'h1234_5678);
      rd(A_IN, rd_val);    chk("in_write_ignored", rd_val, 32'h0000_00FF);

      // Pin 0 glitch train then hold high.
      gpio_i = 8'hFE;
      tick(8);
      rd(A_IN, rd_val);    chk("pin0_low", rd_val, 32'h0000_00FE);
      rd(A_EDGE, rd_val);  chk("fall_no_edge", rd_val, 32'h0);
      gpio_i = 8'hFF; tick(2);
      gpio_i = 8'hFE; tick(2);
      gpio_i = 8'hFF;
      tick(5);
      rd(A_IN, rd_val);    chk("glitch_not_accepted", rd_val, 32'h0000_00FE);
      rd(A_EDGE, rd_val);  chk("glitch_no_edge", rd_val, 32'h0);
      tick(1);
      rd(A_IN, rd_val);    chk("final_rise_accepted", rd_val, 32'h0000_00FF);
      rd(A_EDGE, rd_val);  chk("edge_single_set", rd_val, 32'h0000_0001);

      // Interrupt on pin 0.
      wr(A_EDGE, 32'h1);
      wr(A_IRQEN, 32'h0000_0001);
      chk("irq_idle", {31'h0, irq_o}, 32'h0);
      gpio_i = 8'hFE;
      tick(8);
      gpio_i = 8'hFF;
      tick(5);
      chk("irq_before_accept", {31'h0, irq_o}, 32'h0);
      tick(1);
      chk("irq_on_accept", {31'h0, irq_o}, 32'h1);
      wr(A_EDGE, 32'h0);
      chk("irq_w0_no_change", {31'h0, irq_o}, 32'h1);
      rd(A_EDGE, rd_val);  chk("edge_w0_kept", rd_val, 32'h0000_0001);
      wr(A_EDGE, 32'h1);
      chk("irq_cleared", {31'h0, irq_o}, 32'h0);

      // Same-edge set and clear on pin 3: set wins.
      gpio_i = 8'hF7;
      tick(8);
      rd(A_EDGE, rd_val);  chk("edge_pre_pin3", rd_val, 32'h0);
      gpio_i = 8'hFF;
      tick(5);
      wr(A_EDGE, 32'h0000_0008);
      rd(A_EDGE, rd_val);  chk("edge3_set_wins", rd_val, 32'h0000_0008);
      rd(A_IN, rd_val);    chk("in_pin3_high", rd_val, 32'h0000_00FF);
      wr(A_IRQEN, 32'h0000_0008);
      chk("irq_pin3", {31'h0, irq_o}, 32'h1);

      // Reset mid-debounce on pin 7.
      gpio_i = 8'h7F;
      tick(8);
      gpio_i = 8'hFF;
      tick(4);              // pin 7 counter at 2
      reset_i = 1'b0;
      #1;
      chk("mid_rst_gpio_o", {24'h0, gpio_o}, 32'h0);
      chk("mid_rst_irq", {31'h0, irq_o}, 32'h0);
      rd(A_OUT, rd_val);   chk("mid_rst_out", rd_val, 32'h0);
      rd(A_EDGE, rd_val);  chk("mid_rst_edge", rd_val, 32'h0);
      rd(A_IRQEN, rd_val); chk("mid_rst_irqen", rd_val, 32'h0);
      rd(A_IN, rd_val);    chk("mid_rst_in", rd_val, 32'h0);
      tick(2);
      reset_i = 1'b1;
      tick(5);
      rd(A_IN, rd_val);    chk("post_rst_in_wait", rd_val, 32'h0);
      tick(1);
      rd(A_IN, rd_val);    chk("post_rst_in_ff", rd_val, 32'h0000_00FF);
      rd(A_EDGE, rd_val);  chk("post_rst_edge", rd_val, 32'h0000_00FF);
      chk("post_rst_irq", {31'h0, irq_o}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_gpio_mmio_port
